binary_mul_acc: RTL
===================

Name: binary_mul_acc

Overview:
- Downstream consumer of the 5x5 unsigned array multiplier's registered product.
- Sums a programmed number of consecutive products (dot-product / MAC reduction) into a widened accumulator.
- Accepts products on a valid/ready handshake; presents the final sum on a second valid/ready handshake.
- Sits between the multiplier's P register and the result sink; the operand sequencer drives start/len.

Parameters:
- PW, 10, product width; matches the multiplier output.
- CNT_W, 4, term-count width; a frame holds 1..2^CNT_W terms.
- ACC_W, PW+CNT_W, accumulator width; sized so overflow is impossible.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a new frame; sampled only when the block can accept it.
- len  in  CNT_W  term count, latched on an accepted start; 0 means 2^CNT_W.
- p_in  in  PW  unsigned product from the multiplier.
- p_vld  in  1  p_in valid.
- p_rdy  out  1  block accepts p_in this cycle.
- acc_out  out  ACC_W  frame sum.
- acc_vld  out  1  acc_out valid.
- acc_rdy  in  1  sink accepts acc_out.
- busy  out  1  high in ACC or HOLD.

Behaviour:
- Reset (async assert, sync release): state=IDLE, acc=0, cnt=0, len_q=0, acc_out=0, acc_vld=0, p_rdy=0, busy=0.
- States:
  - IDLE: p_rdy=0, acc_vld=0. On start: len_q<=len, acc<=0, cnt<=0, go to ACC.
  - ACC: p_rdy=1, busy=1.
    - Each cycle with p_vld: acc<=acc+zero-extended p_in, cnt<=cnt+1.
    - Gaps in p_vld: hold acc and cnt.
    - Last term is the accepted beat where cnt==len_q-1, modulo 2^CNT_W, so len_q=0 gives 2^CNT_W terms.
    - On the last term: acc_out<=acc+p_in, acc_vld<=1, go to HOLD.
    - start is ignored in ACC.
  - HOLD: p_rdy=0; acc_vld=1; acc_out stable until acc_rdy.
    - On acc_rdy with start in the same cycle: acc_vld<=0, latch the new len, clear acc and cnt, go straight to ACC (back-to-back frames, no idle bubble).
    - On acc_rdy without start: go to IDLE.
    - start without acc_rdy: ignored.
- Latency:
  - Last accepted product to acc_vld: 1 cycle.
  - start to p_rdy: 1 cycle.
- acc_out holds its last value after the handshake until the next frame completes.
- Width rule: unsigned addition; ACC_W bits always hold 2^CNT_W*(2^PW-1), so no saturation or wrap.
- Reset mid-frame: all state is discarded; the partial sum is never presented.
- p_vld while p_rdy=0: the beat is not consumed. Upstream holds it (valid/ready rule: data stable while vld && !rdy).

Optional Feature:
- Macro: BINARY_MUL_ACC_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort in ACC or HOLD forces IDLE next cycle: acc_vld<=0, acc<=0, cnt<=0; acc_out keeps its previous value.
  - abort has priority over start, p_vld and acc_rdy in the same cycle.
  - abort in IDLE has no effect.
- Undefined: no abort port; the only exit from a frame is its completion handshake (or reset).

Decomposition:
- Package binary_mul_pkg holds:
  - PW/CNT_W defaults and the ACC_W derivation function.
  - State enum IDLE=2'd0, ACC=2'd1, HOLD=2'd2.
  - Shared with the multiplier stage and its sequencer.
- Single module; no sub-module. The term counter and adder are inline. The FSM, counter and output register make up the whole block.

Test Plan:
- Basic frame: start with len=3, three beats p_in=961 with p_vld continuous -> acc_vld rises one cycle after the 3rd beat, acc_out=2883; with acc_rdy=1, return to IDLE.
- Full-length frame: len=0, sixteen beats of 961 -> acc_out=15376, no wrap in 14 bits; exactly 16 beats consumed; the 17th beat sees p_rdy=0.
- Bubbles and backpressure: len=2, p_in=5, then 3 idle cycles, then p_in=7; hold acc_rdy=0 for 5 cycles -> acc_out=12 stable and acc_vld high throughout; p_rdy=0 in HOLD.
- Back-to-back frames: in the HOLD cycle with acc_rdy=1 and start=1, len=1, next beat p_in=100 -> second frame acc_out=100, with no IDLE cycle between frames.
- Reset mid-frame: len=4, two beats of 50, assert rst_n=0 asynchronously -> all outputs 0 immediately; after release, a new frame len=1, p_in=9 gives acc_out=9.
- With BINARY_MUL_ACC_ABORT_EN: len=4, one beat of 20, then abort together with p_vld -> IDLE next cycle, beat not accumulated, acc_vld never asserted; the following frame len=1, p_in=3 gives 3.

Source files
------------

// File: rtl/binary_mul_pkg.sv
// Shared definitions for the 5x5 multiplier stage, its operand sequencer and
// the product accumulator: default widths, accumulator width derivation and
// the accumulator FSM state encoding.
package binary_mul_pkg;

  // Product width of the 5x5 unsigned array multiplier.
  localparam int PW_DEF    = 10;
  // Term-count width; a frame carries 1..2^CNT_W products.
  localparam int CNT_W_DEF = 4;

  // Width that holds 2^cnt_w * (2^pw - 1) without wrapping.
  function automatic int acc_width(input int pw, input int cnt_w);
    return pw + cnt_w;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage : binary_mul_pkg

// File: rtl/binary_mul_acc.sv
// Purpose : sums a programmed number of consecutive multiplier products per frame.
// Latency : start -> p_rdy 1 cycle; last accepted product -> acc_vld 1 cycle.
// Backpressure: p_rdy only in ACC; result held in HOLD until acc_rdy, start
//               accepted together with acc_rdy gives back-to-back frames.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start, len            frame start and term count (0 means 2^CNT_W)
//   p_in, p_vld, p_rdy    product input handshake
//   acc_out, acc_vld,
//   acc_rdy               frame sum output handshake
//   busy                  high while a frame is in progress or being presented
//   abort                 only when BINARY_MUL_ACC_ABORT_EN is defined: drops
//                         the current frame and returns to IDLE
module binary_mul_acc
  import binary_mul_pkg::*;
#(
  parameter int PW    = PW_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ACC_W = acc_width(PW, CNT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [PW-1:0]    p_in,
  input  logic             p_vld,
  output logic             p_rdy,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_vld,
  input  logic             acc_rdy,
`ifdef BINARY_MUL_ACC_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy
);

  state_t             state;
  state_t             state_nxt;

  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   len_q;

  logic [ACC_W-1:0]   acc_sum;
  logic [CNT_W-1:0]   last_idx;

  // Datapath controls decoded by the FSM.
  logic               load_frame;  // latch len, clear acc/cnt
  logic               take_beat;   // accumulate p_in
  logic               last_beat;   // final term: register the sum
  logic               clr_frame;   // drop the frame without presenting it

  assign acc_sum  = acc + ACC_W'(p_in);
  // Modulo-2^CNT_W so that len_q == 0 ends the frame at cnt == all-ones,
  // i.e. after 2^CNT_W terms.
  assign last_idx = len_q - CNT_W'(1);

  // Handshake outputs come straight from the registered state, so they are
  // glitch-free and drop to zero as soon as reset asserts.
  assign p_rdy   = (state == ACC);
  assign acc_vld = (state == HOLD);
  assign busy    = (state != IDLE);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    load_frame = 1'b0;
    take_beat  = 1'b0;
    last_beat  = 1'b0;
    clr_frame  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          load_frame = 1'b1;
          state_nxt  = ACC;
        end
      end

      ACC: begin
        // start is deliberately ignored here; the frame length is fixed.
        if (p_vld) begin
          take_beat = 1'b1;
          if (cnt == last_idx) begin
            last_beat = 1'b1;
            state_nxt = HOLD;
          end
        end
      end

      HOLD: begin
        if (acc_rdy) begin
          if (start) begin
            // Result leaves and the next frame opens in the same cycle.
            load_frame = 1'b1;
            state_nxt  = ACC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

`ifdef BINARY_MUL_ACC_ABORT_EN
    // abort outranks every other request while a frame is open.
    if (abort && (state != IDLE)) begin
      state_nxt  = IDLE;
      load_frame = 1'b0;
      take_beat  = 1'b0;
      last_beat  = 1'b0;
      clr_frame  = 1'b1;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Accumulator, term counter and frame length
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else begin
      if (load_frame || clr_frame) begin
        acc <= '0;
        cnt <= '0;
      end else if (take_beat) begin
        acc <= acc_sum;
        cnt <= cnt + CNT_W'(1);
      end
      if (load_frame) begin
        len_q <= len;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result register: only written on the last term, so it keeps the previous
  // frame's sum through the handshake, idle periods and aborts.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out <= '0;
    end else if (last_beat) begin
      acc_out <= acc_sum;
    end
  end

endmodule : binary_mul_acc
